// File: rtl/data_cache_wb.sv
// data_cache_wb: set-associative, write-back, write-allocate data cache.
//
// Sits between the core load/store unit and main memory. Hits are answered
// combinationally in the same cycle. A miss picks a victim way (lowest invalid
// way, else the set's round-robin pointer), writes the victim line back if it
// is dirty, and then fills the line from memory one word per handshake.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   proc_addr      request word address {tag, index, offset}
//   proc_rd_en     load request (wins over proc_wr_en)
//   proc_wr_en     store request
//   proc_wr_data   store data
//   proc_wr_sel    store byte enables
//   proc_rd_data   load data, valid when proc_hit, else 0
//   proc_hit       request hits (idle only, combinational)
//   proc_busy      miss handling in progress
//   mem_rd_*       fill request/address and returned data/valid
//   mem_wr_*       eviction word offer (addr/data/en) and memory ready
module data_cache_wb #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 4,
    parameter int unsigned ASSOC      = 2,
    parameter int unsigned NUM_SETS   = 256
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   proc_addr,
    input  logic                    proc_rd_en,
    input  logic                    proc_wr_en,
    input  logic [DATA_WIDTH-1:0]   proc_wr_data,
    input  logic [DATA_WIDTH/8-1:0] proc_wr_sel,
    output logic [DATA_WIDTH-1:0]   proc_rd_data,
    output logic                    proc_hit,
    output logic                    proc_busy,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    output logic                    mem_rd_en,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    input  logic                    mem_rd_valid,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic                    mem_wr_en,
    input  logic                    mem_wr_rdy
);

    localparam int unsigned OFF_W = $clog2(LINE_WIDTH);
    localparam int unsigned IDX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int unsigned WAY_W = $clog2(ASSOC);
    localparam int unsigned SEL_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StEvict, StFill} state_e;

    // Storage. Line data and tags carry no reset; valid/dirty/rr do.
    logic [DATA_WIDTH-1:0] data_q [ASSOC][NUM_SETS][LINE_WIDTH];
    logic [TAG_W-1:0]      tag_q  [ASSOC][NUM_SETS];
    logic [ASSOC-1:0][NUM_SETS-1:0]   valid_q;
    logic [ASSOC-1:0][NUM_SETS-1:0]   dirty_q;
    logic [NUM_SETS-1:0][WAY_W-1:0]   rr_q;

    // Miss context latched when the miss is detected.
    state_e           state_q, state_d;
    logic [OFF_W-1:0] wcnt_q, rcnt_q;
    logic [TAG_W-1:0] mtag_q, vtag_q;
    logic [IDX_W-1:0] idx_q;
    logic [WAY_W-1:0] vway_q;
    logic             vrr_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    assign {req_tag, req_idx, req_off} = proc_addr;

    logic req_valid, req_is_wr;
    assign req_valid = proc_rd_en | proc_wr_en;
    assign req_is_wr = proc_wr_en & ~proc_rd_en;

    // Tag lookup and victim choice for the presented address.
    logic             hit_any, inv_any;
    logic [WAY_W-1:0] hit_way, inv_way;
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[w][req_idx] && !inv_any) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    logic [WAY_W-1:0] victim_way;
    logic             victim_dirty;
    assign victim_way   = inv_any ? inv_way : rr_q[req_idx];
    assign victim_dirty = valid_q[victim_way][req_idx] & dirty_q[victim_way][req_idx];

    assign proc_hit     = (state_q == StIdle) & req_valid & hit_any;
    assign proc_rd_data = proc_hit ? data_q[hit_way][req_idx][req_off] : '0;
    assign proc_busy    = (state_q != StIdle);

    // Next state, memory-side outputs and the update strobes.
    logic miss_start, wr_hit, evict_acc, evict_last, fill_word, fill_last;
    always_comb begin
        state_d     = state_q;
        miss_start  = 1'b0;
        wr_hit      = 1'b0;
        evict_acc   = 1'b0;
        evict_last  = 1'b0;
        fill_word   = 1'b0;
        fill_last   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (state_q)
            StIdle: begin
                if (req_valid && hit_any) begin
                    wr_hit = req_is_wr;
                end else if (req_valid) begin
                    miss_start = 1'b1;
                    state_d    = victim_dirty ? StEvict : StFill;
                end
            end
            StEvict: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = {vtag_q, idx_q, wcnt_q};
                mem_wr_data = data_q[vway_q][idx_q][wcnt_q];
                if (mem_wr_rdy) begin
                    evict_acc = 1'b1;
                    if (wcnt_q == '1) begin
                        evict_last = 1'b1;
                        state_d    = StFill;
                    end
                end
            end
            StFill: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = {mtag_q, idx_q, rcnt_q};
                if (mem_rd_valid) begin
                    fill_word = 1'b1;
                    if (rcnt_q == '1) begin
                        fill_last = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, line status bits and replacement pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            mtag_q  <= '0;
            vtag_q  <= '0;
            idx_q   <= '0;
            vway_q  <= '0;
            vrr_q   <= 1'b0;
            valid_q <= '0;
            dirty_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                mtag_q <= req_tag;
                idx_q  <= req_idx;
                vway_q <= victim_way;
                vtag_q <= tag_q[victim_way][req_idx];
                vrr_q  <= ~inv_any;
                wcnt_q <= '0;
                rcnt_q <= '0;
            end
            if (wr_hit) begin
                dirty_q[hit_way][req_idx] <= 1'b1;
            end
            if (evict_acc) begin
                wcnt_q <= wcnt_q + OFF_W'(1);
            end
            if (evict_last) begin
                valid_q[vway_q][idx_q] <= 1'b0;
                dirty_q[vway_q][idx_q] <= 1'b0;
            end
            if (fill_word) begin
                rcnt_q <= rcnt_q + OFF_W'(1);
            end
            if (fill_last) begin
                valid_q[vway_q][idx_q] <= 1'b1;
                dirty_q[vway_q][idx_q] <= 1'b0;
                // Only an rr-chosen victim advances the pointer; wraps mod ASSOC.
                if (vrr_q) begin
                    rr_q[idx_q] <= vway_q + WAY_W'(1);
                end
            end
        end
    end

    // Line data and tags: byte-merged store hits and fill words.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (proc_wr_sel[b]) begin
                    data_q[hit_way][req_idx][req_off][8*b +: 8] <= proc_wr_data[8*b +: 8];
                end
            end
        end
        if (fill_word) begin
            data_q[vway_q][idx_q][rcnt_q] <= mem_rd_data;
        end
        if (fill_last) begin
            tag_q[vway_q][idx_q] <= mtag_q;
        end
    end

endmodule

// File: doc/data_cache_wb.md
Name: data_cache_wb

Overview:
- Parametrised set-associative, write-back, write-allocate data cache between the core load/store unit and main memory.
- Successor to the write-through data cache. Adds per-line dirty bits, dirty-victim eviction bursts, a per-set round-robin replacement pointer, and byte-lane write merging.
- Single processor request port. Memory side uses separate word-wise read and write handshakes.

Parameters:
- ADDR_WIDTH, 16: word address width.
- DATA_WIDTH, 32: word width in bits; multiple of 8.
- LINE_WIDTH, 4: words per line; power of two, >=2.
- ASSOC, 2: ways per set; power of two, >=2.
- NUM_SETS, 256: number of sets; power of two.
- Derived: OFF_W=log2(LINE_WIDTH), IDX_W=log2(NUM_SETS), TAG_W=ADDR_WIDTH-IDX_W-OFF_W, WAY_W=log2(ASSOC).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- proc_addr  in  ADDR_WIDTH  request word address
- proc_rd_en  in  1  load request
- proc_wr_en  in  1  store request
- proc_wr_data  in  DATA_WIDTH  store data
- proc_wr_sel  in  DATA_WIDTH/8  store byte enables
- proc_rd_data  out  DATA_WIDTH  load data, valid when proc_hit
- proc_hit  out  1  request hits (combinational, IDLE only)
- proc_busy  out  1  miss handling in progress
- mem_rd_addr  out  ADDR_WIDTH  fill word address
- mem_rd_en  out  1  fill request
- mem_rd_data  in  DATA_WIDTH  fill data
- mem_rd_valid  in  1  fill word delivered
- mem_wr_addr  out  ADDR_WIDTH  eviction word address
- mem_wr_data  out  DATA_WIDTH  eviction data
- mem_wr_en  out  1  eviction word offered
- mem_wr_rdy  in  1  memory accepts eviction word

Behaviour:
- Address split: proc_addr = {tag, index, offset}.
- Per way/set storage: valid, dirty, tag, LINE_WIDTH words. Per set: rr pointer (WAY_W bits).
- Reset (async, rstn=0): state=IDLE; all valid, dirty and rr bits cleared; counters 0; mem_rd_en=0, mem_wr_en=0, proc_busy=0, proc_hit=0. Line data is not cleared.
- Reset mid-burst: the burst is abandoned immediately with no further memory handshakes, and the partially filled line stays invalid.
- Request selection: proc_rd_en has priority over proc_wr_en when both are high. In IDLE, hit = valid && tag match in any way. proc_hit and proc_rd_data are combinational in the same cycle; proc_rd_data=0 when there is no hit.
- Write hit: at the clock edge, only bytes with proc_wr_sel=1 are updated and dirty is set. No memory traffic.
- Miss in IDLE, victim way selection: lowest-index invalid way; otherwise the way at rr[index].
- Miss in IDLE, latched at the edge: tag, index, victim way and victim tag. Next state is EVICT if the victim is valid and dirty, else FILL. proc_busy rises the cycle after the miss.
- EVICT: mem_wr_en=1, mem_wr_addr={victim_tag,index,wcnt}, mem_wr_data=victim word wcnt.
  - wcnt advances only on mem_wr_en && mem_wr_rdy; outputs hold stable while rdy=0.
  - After word LINE_WIDTH-1 is accepted, go to FILL; victim valid and dirty are cleared.
- FILL: mem_rd_en=1, mem_rd_addr={miss_tag,index,rcnt}.
  - Each cycle with mem_rd_valid=1, word rcnt is written into the victim way and rcnt increments.
  - mem_rd_valid is ignored outside FILL.
  - On the edge receiving word LINE_WIDTH-1: set valid=1, dirty=0, tag=miss_tag; rr[index] = victim+1 (mod ASSOC) if the victim was chosen by rr, otherwise unchanged; return to IDLE.
- After a miss: the processor holds its request while proc_busy=1. On return to IDLE the request hits.
  - A write miss is allocated, then written on that hit cycle.
  - Requests while busy are ignored, and proc_hit=0 while busy.
- Memory enables are 0 in IDLE. Cache state changes only via the listed events.
- Latency: hit = 0 cycles. Clean miss = 1 + LINE_WIDTH fill handshakes. Dirty miss additionally adds LINE_WIDTH accepted writes.

Test Plan:
- Cold load 0x0010 with memory words 0x0010..0x0013 = 0xA0..0xA3, mem_rd_valid every cycle:
  - proc_busy for 4 cycles.
  - mem_rd_addr sequence 0x0010..0x0013.
  - Load 0x0012 then hits with 0xA2, no mem_wr_en.
- Store 0x0011 data 0x11223344, sel 4'b0101, onto a resident line word 0xA1 -> read returns 0x002200 merged with 0xA1's bytes 1 and 3, i.e. 0x00220044 when 0xA1 = 0x000000A1 (byte 1 = 0x00 unchanged from 0xA1's byte 1). Line becomes dirty, zero memory traffic.
- Fill set 4 with tags 0 (0x0010, dirty) and 1 (0x0410, clean), then load 0x0810 -> way 0 (rr) evicted:
  - mem_wr_addr 0x0010..0x0013 with merged data, then fill 0x0810..0x0813.
  - rr[4]=1.
  - Next miss tag 3 (0x0C10) evicts way 1 with no write burst.
- Eviction with mem_wr_rdy low 3 cycles per word -> mem_wr_addr/data held stable; exactly 4 accepted writes.
- Assert rstn=0 mid-FILL after 2 words -> outputs 0 immediately (async). Load 0x0010 then misses and refills all 4 words.
- proc_rd_en and proc_wr_en together on a miss -> read address used for the fill; memory state unchanged by the write.
